regfile_wb_arbiter: RTL

Shares the register file's single write-back port between two producers. Port A is the in-order pipeline write-back, which has no backpressure. Port B is a multi-cycle unit such as a multiplier, using a valid/ready handshake and a 2-entry buffer. A 15-entry busy scoreboard tracks outstanding port-B destinations, so issue logic can detect RAW/WAW hazards. A starvation counter raises a pipeline stall so port B always drains.

---
 rtl/regfile_wb_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the register file's single write-back port between the in-order
// pipeline (port A, no backpressure) and a multi-cycle unit (port B,
// valid/ready into a 2-entry buffer). It also keeps a busy scoreboard of
// outstanding port-B destinations and raises stall_req when the B buffer
// starves.
//
// Optional build macro: WB_BYPASS_EN
//   defined   : a register being written by a B grant this cycle is not
//               reported as a hazard. The register file writes on the
//               negedge, so decode can read the value in the same cycle.
//   undefined : hazard comes only from the registered busy bits, so the
//               hazard clears one cycle after the write.
//
// Register 15 is the PC and does not exist in the file. Writes to it are
// dropped, but the item is still consumed. It never becomes busy and never
// flags a hazard.

module regfile_wb_arbiter #(
    parameter int WIDTH        = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [3:0]       a_dest,
    input  logic [WIDTH-1:0] a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [3:0]       b_dest,
    input  logic [WIDTH-1:0] b_data,
    input  logic             iss_valid,
    input  logic [3:0]       iss_dest,
    input  logic [3:0]       chk_src1,
    input  logic [3:0]       chk_src2,
    input  logic [3:0]       chk_dest,
    output logic             hazard,
    output logic             stall_req,
    output logic             wb_en,
    output logic [3:0]       wb_dest,
    output logic [WIDTH-1:0] wb_data
);

    localparam logic [3:0] PC_REG    = 4'd15;
    localparam logic [3:0] STARVE_TH = 4'(STARVE_LIMIT);

    // Port-B buffer: two slots addressed by 1-bit read and write pointers.
    logic [3:0]       fifo_dest [2];
    logic [WIDTH-1:0] fifo_data [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;

    logic [14:0]      busy;
    logic [14:0]      busy_next;
    logic [14:0]      live_busy;
    logic [3:0]       starve_cnt;

    logic             b_nonempty;
    logic [3:0]       head_dest;
    logic [WIDTH-1:0] head_data;
    logic             grant_a;
    logic             grant_b;
    logic [3:0]       sel_dest;
    logic [WIDTH-1:0] sel_data;
    logic             push;
    logic             pop;
    logic             b_write;

    // Grant selection and write-back port drive. Everything is forced idle
    // while rst is high.
    always_comb begin
        b_nonempty = (count != 2'd0);
        head_dest  = fifo_dest[rd_ptr];
        head_data  = fifo_data[rd_ptr];

        b_ready    = !rst && (count < 2'd2);
        stall_req  = !rst && b_nonempty && (starve_cnt >= STARVE_TH);

        // B goes first when it is starving. Otherwise A goes first, and B
        // takes any cycle that A leaves free.
        grant_b    = !rst && b_nonempty && (stall_req || !a_valid);
        grant_a    = !rst && a_valid && !grant_b;

        sel_dest   = grant_b ? head_dest : a_dest;
        sel_data   = grant_b ? head_data : a_data;

        wb_en      = (grant_a || grant_b) && (sel_dest != PC_REG);
        wb_dest    = wb_en ? sel_dest : 4'd0;
        wb_data    = wb_en ? sel_data : '0;

        push       = b_valid && b_ready;
        pop        = grant_b;
        b_write    = grant_b && wb_en;
    end

    // Next busy vector. A set and a clear of the same register in one cycle
    // leave the register set.
    always_comb begin
        busy_next = busy;
        for (int i = 0; i < 15; i++) begin
            if (b_write && (wb_dest == 4'(i)))
                busy_next[i] = 1'b0;
            if (iss_valid && (iss_dest == 4'(i)))
                busy_next[i] = 1'b1;
        end
    end

    // Hazard lookup. Register 15 has no busy bit, so it never matches.
    always_comb begin
        live_busy = busy;
`ifdef WB_BYPASS_EN
        for (int i = 0; i < 15; i++) begin
            if (b_write && (wb_dest == 4'(i)))
                live_busy[i] = 1'b0;
        end
`endif
        hazard = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (live_busy[i] &&
                ((chk_src1 == 4'(i)) || (chk_src2 == 4'(i)) || (chk_dest == 4'(i))))
                hazard = 1'b1;
        end
    end

    // Port-B buffer storage, pointers and occupancy. Push and pop in the
    // same cycle leave count unchanged and keep the FIFO order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_dest[i] <= 4'd0;
                fifo_data[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_dest[wr_ptr] <= b_dest;
                fifo_data[wr_ptr] <= b_data;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Busy scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_next;
    end

    // Starvation counter. It counts the cycles a queued B head waits and
    // saturates at 15.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve_cnt <= 4'd0;
        else if (!b_nonempty || grant_b)
            starve_cnt <= 4'd0;
        else if (starve_cnt != 4'hF)
            starve_cnt <= starve_cnt + 4'd1;
    end

endmodule
